// File: rtl/key_event_pkg.sv
// Shared types and helpers for the keypad press-event detector.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
//
// Contents:
//   state_t        - controller states.
//   CNT_W          - width of the saturating debounce counter.
//   is_single_hot  - true when exactly one bit of a vector is set.
//   onehot_to_code - binary index of the set bit of a one-hot vector.
package key_event_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE,
        LOCKOUT
    } state_t;

    // v nonzero and clearing its lowest set bit leaves nothing.
    function automatic logic is_single_hot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    // OR of the indices of all set bits; exact for one-hot input.
    function automatic logic [4:0] onehot_to_code(input logic [31:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                c = c | 5'(i);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous lines.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
//
// Ports:
//   clk - sampling clock
//   rst - asynchronous active-high reset, clears both stages
//   d   - asynchronous input lines
//   q   - synchronised lines
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_event_detector.sv
// Keypad front end: synchronise, debounce, reject multi-key, emit one press event per key-down.
// Latency: event registered DEBOUNCE_CYCLES + 2 cycles after the key line settles.
// Backpressure: none; events are one-cycle strobes that the consumer must take.
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   in         - raw asynchronous key lines, active high
//   key_valid  - one-cycle press event strobe
//   key_onehot - key of the event, zero when key_valid is low
//   key_code   - binary index of that key, zero when key_valid is low
//   multi_err  - one-cycle strobe: several keys were held stably together
//   busy       - high whenever the controller is not idle
//
// Build option: define KEY_EVENT_REPEAT_EN to add auto-repeat while a single
// key stays held (first repeat REPEAT_DELAY cycles after the press event,
// then every REPEAT_PERIOD cycles).
module key_event_detector
    import key_event_pkg::*;
#(
    parameter int N_KEYS          = 10,
    parameter int CODE_W          = $clog2(N_KEYS),
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] in,
    output logic              key_valid,
    output logic [N_KEYS-1:0] key_onehot,
    output logic [CODE_W-1:0] key_code,
    output logic              multi_err,
    output logic              busy
);

    localparam logic [CNT_W-1:0] DB = CNT_W'(DEBOUNCE_CYCLES);

    state_t            state;
    logic [N_KEYS-1:0] s;
    logic [N_KEYS-1:0] cand;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;

    // Debounce decision inputs. In IDLE the candidate is not yet latched, so
    // a one-sample debounce decides on the live synchronised value.
    logic [N_KEYS-1:0] dvec;
    logic              d_single;
    logic [CODE_W-1:0] d_code;
    logic              fire;

    sync_2ff #(
        .WIDTH (N_KEYS)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in),
        .q   (s)
    );

    assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
    assign dvec     = (state == IDLE) ? s : cand;
    assign d_single = is_single_hot(32'(dvec));
    assign d_code   = CODE_W'(onehot_to_code(32'(dvec)));
    assign busy     = (state != IDLE);

    // The sample that completes DEBOUNCE_CYCLES stable samples.
    always_comb begin
        fire = 1'b0;
        case (state)
            IDLE:     fire = (s != '0) && (DB <= 1);
            DEBOUNCE: fire = (s != '0) && (s == cand) && (cnt_inc >= DB);
            default:  fire = 1'b0;
        endcase
    end

`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] RD = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RP = CNT_W'(REPEAT_PERIOD);

    logic [CNT_W-1:0] rpt;
    logic [CNT_W-1:0] rpt_inc;
    logic             rpt_first;  // still waiting for the first (longer) interval

    assign rpt_inc = (rpt == '1) ? rpt : rpt + 1'b1;
`else
    logic unused_rpt_params;
    assign unused_rpt_params = (REPEAT_DELAY != 0) ^ (REPEAT_PERIOD != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cand       <= '0;
            cnt        <= '0;
            key_valid  <= 1'b0;
            key_onehot <= '0;
            key_code   <= '0;
            multi_err  <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
            rpt        <= '0;
            rpt_first  <= 1'b1;
`endif
        end else begin
            key_valid  <= 1'b0;
            key_onehot <= '0;
            key_code   <= '0;
            multi_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (s != '0) begin
                        cand  <= s;
                        cnt   <= 1;
                        state <= DEBOUNCE;
                    end
                end

                DEBOUNCE: begin
                    if (s == '0) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (s == cand) begin
                        cnt <= cnt_inc;
                    end else begin
                        // Pattern changed: restart the filter on the new pattern.
                        cand <= s;
                        cnt  <= 1;
                    end
                end

                PRESSED: begin
                    if (s == '0) begin
                        cnt   <= 1;
                        state <= (DB <= 1) ? IDLE : RELEASE;
                    end else begin
`ifdef KEY_EVENT_REPEAT_EN
                        if (s == cand) begin
                            if (rpt >= (rpt_first ? RD : RP)) begin
                                key_valid  <= 1'b1;
                                key_onehot <= cand;
                                key_code   <= d_code;
                                rpt        <= 1;
                                rpt_first  <= 1'b0;
                            end else begin
                                rpt <= rpt_inc;
                            end
                        end else begin
                            rpt       <= '0;
                            rpt_first <= 1'b1;
                        end
`endif
                    end
                end

                RELEASE: begin
                    if (s == '0) begin
                        cnt <= cnt_inc;
                        if (cnt_inc >= DB) begin
                            state <= IDLE;
                        end
                    end else begin
                        // Release bounce: key is still considered down.
                        state <= PRESSED;
`ifdef KEY_EVENT_REPEAT_EN
                        rpt       <= 1;
                        rpt_first <= 1'b1;
`endif
                    end
                end

                LOCKOUT: begin
                    if (s == '0) begin
                        cnt <= cnt_inc;
                        if (cnt_inc >= DB) begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end

                default: state <= IDLE;
            endcase

            // Debounce complete: overrides the state/count updates above.
            if (fire) begin
                if (d_single) begin
                    key_valid  <= 1'b1;
                    key_onehot <= dvec;
                    key_code   <= d_code;
                    state      <= PRESSED;
`ifdef KEY_EVENT_REPEAT_EN
                    rpt        <= 1;
                    rpt_first  <= 1'b1;
`endif
                end else begin
                    multi_err <= 1'b1;
                    cnt       <= '0;
                    state     <= LOCKOUT;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_event_detector.sv
// Scoreboard bench for key_event_detector (N_KEYS=10, DEBOUNCE_CYCLES=4).
// Expected events are queued with their sample cycle when stimulus is driven
// and matched against key_valid / multi_err strobes sampled on negedge.
module tb_key_event_detector;

    localparam int N  = 10;
    localparam int CW = 4;
    localparam int D  = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  in;
    logic          key_valid;
    logic [N-1:0]  key_onehot;
    logic [CW-1:0] key_code;
    logic          multi_err;
    logic          busy;

    key_event_detector #(
        .N_KEYS          (N),
        .CODE_W          (CW),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .key_valid  (key_valid),
        .key_onehot (key_onehot),
        .key_code   (key_code),
        .multi_err  (multi_err),
        .busy       (busy)
    );

    typedef struct {
        int           cyc;
        logic [N-1:0] oh;
        logic [CW-1:0] code;
    } ev_t;

    ev_t exp_q[$];
    int  multi_q[$];
    ev_t e;
    int  mc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Input applied at the current negedge is first sampled at the next
    // posedge; the event is registered 1 + D edges later and seen here at
    // the negedge after that.
    task automatic expect_key(input logic [N-1:0] oh, input logic [CW-1:0] code, input int dly);
        ev_t x;
        x.cyc  = cyc + D + 2 + dly;
        x.oh   = oh;
        x.code = code;
        exp_q.push_back(x);
    endtask

    // Monitor: every strobe must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            chk("both_strobes", {31'd0, key_valid & multi_err}, 32'd0);
            if (key_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_key", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("key_cyc", cyc, e.cyc);
                    chk("key_onehot", 32'(key_onehot), 32'(e.oh));
                    chk("key_code", 32'(key_code), 32'(e.code));
                end
            end else begin
                chk("idle_onehot", 32'(key_onehot), 32'd0);
                chk("idle_code", 32'(key_code), 32'd0);
            end
            if (multi_err) begin
                if (multi_q.size() == 0) begin
                    chk("spurious_multi", 32'd1, 32'd0);
                end else begin
                    mc = multi_q.pop_front();
                    chk("multi_cyc", cyc, mc);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        in  = '0;
        tick(3);
        chk("rst_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_onehot", 32'(key_onehot), 32'd0);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_multi", {31'd0, multi_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick(3);

        // Clean single press, held; then release timing of busy.
        in = 10'h008;
        expect_key(10'h008, 4'd3, 0);
        tick(20);
        chk("held_busy", {31'd0, busy}, 32'd1);
        in = '0;
        tick(D + 1);
        chk("release_busy_hi", {31'd0, busy}, 32'd1);
        tick(1);
        chk("release_busy_lo", {31'd0, busy}, 32'd0);
        tick(8);

        // Bounce on press: no event until the line stays put.
        for (int i = 0; i < 3; i++) begin
            in = 10'h008;
            tick(2);
            in = '0;
            tick(2);
        end
        in = 10'h008;
        expect_key(10'h008, 4'd3, 0);
        tick(15);
        in = '0;
        tick(10);

        // Two keys together: multi_err, lockout, then a normal press.
        in = 10'h009;
        multi_q.push_back(cyc + D + 2);
        tick(10);
        in = '0;
        tick(6);
        in = 10'h001;
        expect_key(10'h001, 4'd0, 0);
        tick(15);
        in = '0;
        tick(10);

        // Extra key added after the event is ignored.
        in = 10'h004;
        expect_key(10'h004, 4'd2, 0);
        tick(8);
        in = 10'h014;
        tick(8);
        in = '0;
        tick(10);

        // Reset during debounce aborts; fresh debounce after release of rst.
        in = 10'h200;
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("midrst_valid", {31'd0, key_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_onehot", 32'(key_onehot), 32'd0);
        tick(3);
        rst = 1'b0;
        expect_key(10'h200, 4'd9, 0);
        tick(12);
        in = '0;
        tick(10);

`ifdef KEY_EVENT_REPEAT_EN
        // Auto-repeat: original event then t+20, t+25, t+30, t+35.
        in = 10'h002;
        expect_key(10'h002, 4'd1, 0);
        expect_key(10'h002, 4'd1, 20);
        expect_key(10'h002, 4'd1, 25);
        expect_key(10'h002, 4'd1, 30);
        expect_key(10'h002, 4'd1, 35);
        tick(40);
        in = '0;
        tick(15);
`endif

        tick(5);
        chk("pending_keys", exp_q.size(), 32'd0);
        chk("pending_multi", multi_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
